sonic_ranger: RTL

Ultrasonic ranging front end for the HC-SR04 sensor on the line-following car. Issues a periodic trigger pulse and times the returning echo in microseconds. Converts the echo width to centimetres and produces a hysteretic `stop` flag for the top level to use when gating the motor direction outputs. Sits between the `echo`/`trig` board pins and the top-level `stop` wire.

---
 rtl/sonic_ranger_if.sv | 14 +
 rtl/sonic_ranger.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sonic_ranger_if.sv
// Sensor-side and status signals of the ultrasonic ranger, bundled so the
// ranger and whatever consumes its result share one connection.
interface sonic_ranger_if;
  logic       echo;      // raw HC-SR04 echo pin (asynchronous to clk)
  logic       trig;      // registered trigger to the sensor
  logic [9:0] distance;  // last range in cm, 10'h3FF = no echo
  logic       valid;     // one-cycle pulse when distance/stop update
  logic       stop;      // hysteretic obstacle flag

  // Ranger side: samples echo, drives trigger and results.
  modport master (input echo, output trig, distance, valid, stop);
  // Sensor/consumer side: drives echo, observes trigger and results.
  modport slave  (output echo, input trig, distance, valid, stop);
endinterface

// File: rtl/sonic_ranger.sv
// HC-SR04 ranging front end: periodic trigger, echo timing in 1 us ticks,
// conversion to whole centimetres and a hysteretic stop flag.
module sonic_ranger #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 30000,
  parameter int US_PER_CM  = 58,
  parameter int STOP_CM    = 40,
  parameter int GO_CM      = 50
) (
  input  logic           clk,
  input  logic           rst,
  sonic_ranger_if.master bus
);

  localparam int         DIV     = CLK_HZ / 1_000_000;
  localparam int         PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [9:0] NO_ECHO = 10'h3FF;
  localparam logic [9:0] CM_MAX  = 10'd1022;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_HOLD
  } state_t;

  state_t      r_state, w_next;
  logic [PW-1:0] r_pre;
  logic        w_tick;
  logic [1:0]  r_sync;
  logic        r_echo_d;
  logic        w_rise, w_fall;
  logic [15:0] r_period, r_tmr;
  logic [5:0]  r_sub;
  logic [9:0]  r_cm;
  logic        w_trig_done, w_timeout;
  logic        w_report;
  logic [9:0]  w_report_dist;
  logic        r_trig, r_valid, r_stop;
  logic [9:0]  r_distance;

  assign w_tick      = (r_pre == PW'(DIV - 1));
  assign w_rise      =  r_sync[1] & ~r_echo_d;
  assign w_fall      = ~r_sync[1] &  r_echo_d;
  assign w_trig_done = (r_tmr == 16'(TRIG_US - 1));
  assign w_timeout   = (r_tmr == 16'(TIMEOUT_US - 1));

  // Free-running 1 us prescaler; only rst restarts its phase.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)         r_pre <= '0;
    else if (w_tick) r_pre <= '0;
    else             r_pre <= r_pre + 1'b1;
  end

  // Two-stage echo synchronizer plus the previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 2'b00;
      r_echo_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], bus.echo};
      r_echo_d <= r_sync[1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and measurement report; a falling edge beats a same-cycle timeout.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    w_next        = r_state;
    w_report      = 1'b0;
    w_report_dist = NO_ECHO;
    case (r_state)
      S_IDLE:      w_next = S_TRIG;
      S_TRIG:      if (w_tick && w_trig_done) w_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (w_rise) begin
          w_next = S_MEASURE;
        end else if (w_tick && w_timeout) begin
          w_report = 1'b1;
          w_next   = S_HOLD;
        end
      end
      S_MEASURE: begin
        if (w_fall) begin
          w_report      = 1'b1;
          w_report_dist = r_cm;
          w_next        = S_HOLD;
        end else if (w_tick && w_timeout) begin
          w_report = 1'b1;
          w_next   = S_HOLD;
        end
      end
      S_HOLD:      if (r_period >= 16'(PERIOD_US)) w_next = S_TRIG;
      default:     w_next = S_IDLE;
    endcase
  end

  // Period counter from trigger start; per-state tick timer and cm counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= '0;
      r_tmr    <= '0;
      r_sub    <= '0;
      r_cm     <= '0;
    end else begin
      if (r_state == S_IDLE || (w_next == S_TRIG && r_state != S_TRIG))
        r_period <= '0;
      else if (w_tick && r_period != 16'hFFFF)
        r_period <= r_period + 16'd1;

      if (w_next != r_state) begin
        r_tmr <= '0;
        r_sub <= '0;
        r_cm  <= '0;
      end else if (w_tick && r_state != S_HOLD) begin
        r_tmr <= r_tmr + 16'd1;
        if (r_state == S_MEASURE) begin
          if (r_sub == 6'(US_PER_CM - 1)) begin
            r_sub <= '0;
            if (r_cm != CM_MAX) r_cm <= r_cm + 10'd1;
          end else begin
            r_sub <= r_sub + 6'd1;
          end
        end
      end
    end
  end

  // Registered outputs; distance, valid and stop change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig     <= 1'b0;
      r_valid    <= 1'b0;
      r_distance <= NO_ECHO;
      r_stop     <= 1'b0;
    end else begin
      r_trig  <= (r_state == S_TRIG);
      r_valid <= w_report;
      if (w_report) begin
        r_distance <= w_report_dist;
        if (!r_stop && w_report_dist < 10'(STOP_CM))
          r_stop <= 1'b1;
        else if (r_stop && w_report_dist >= 10'(GO_CM))
          r_stop <= 1'b0;
      end
    end
  end

  assign bus.trig     = r_trig;
  assign bus.valid    = r_valid;
  assign bus.distance = r_distance;
  assign bus.stop     = r_stop;

endmodule
